// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
//
// Purpose:
//   Consumer end of the seven-segment clock chain. Detects rising edges of the
//   slow scan clock on the fast system clock and time-multiplexes a latched hex
//   value across DIGITS common-anode digits. A blanking gap of BLANK_CYCLES
//   cycles separates consecutive digits to suppress ghosting. New values are
//   offered through a valid/ready handshake into a single pending slot. That
//   slot is only committed to the displayed (shadow) value at a frame boundary,
//   so a frame never mixes two values.
//
// Parameters:
//   DIGITS        number of multiplexed digits (data width is 4*DIGITS)
//   BLANK_CYCLES  all-anodes-off cycles between digits (>= 1)
//
// Optional feature:
//   SEVENSEG_LEADING_ZERO_BLANK_EN  when defined, digits above the highest
//                                   nonzero nibble stay dark (anode enabled,
//                                   segments off, dp still honoured). Digit 0
//                                   always shows.
//
// Ports:
//   i_cmos_clock   100 MHz system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_scan_clock   divided scan clock (already registered upstream)
//   i_load_valid   new value offered on i_load_data / i_load_dp
//   i_load_data    hex nibbles, nibble 0 is the rightmost digit
//   i_load_dp      decimal-point enables, 1 = lit
//   o_load_ready   pending slot empty (registered)
//   o_anodes       active-low digit enables
//   o_cathodes     active-low segments {g,f,e,d,c,b,a}
//   o_dp_out       active-low decimal point
//   o_frame_start  one-cycle pulse on the cycle digit 0 is first driven
// -----------------------------------------------------------------------------
module seven_seg_scan_driver #(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  i_cmos_clock,
  input  logic                  i_rst_n,
  input  logic                  i_scan_clock,
  input  logic                  i_load_valid,
  input  logic [4*DIGITS-1:0]   i_load_data,
  input  logic [DIGITS-1:0]     i_load_dp,
  output logic                  o_load_ready,
  output logic [DIGITS-1:0]     o_anodes,
  output logic [6:0]            o_cathodes,
  output logic                  o_dp_out,
  output logic                  o_frame_start
);

  localparam int unsigned DataW = 4 * DIGITS;
  localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntW  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);
  localparam logic [CntW-1:0] GapInit = CntW'(BLANK_CYCLES - 1);

  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("BLANK_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    StIdle,
    StShow,
    StGap
  } state_e;

  // ---------------------------------------------------------------------------
  // Hex to active-low segment decode, bit order {g,f,e,d,c,b,a}
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  // Index of the most significant nonzero nibble; 0 when the value is zero so
  // that digit 0 is always shown.
  function automatic logic [IdxW-1:0] top_nonzero(input logic [DataW-1:0] data);
    logic [IdxW-1:0] top;
    top = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (data[4*i +: 4] != 4'h0) begin
        top = IdxW'(i);
      end
    end
    return top;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic              r_scan_prev;
  state_e            r_state;
  logic [IdxW-1:0]   r_idx;
  logic [CntW-1:0]   r_cnt;

  logic [DataW-1:0]  r_pend_data;
  logic [DIGITS-1:0] r_pend_dp;
  logic              r_pend_full;
  logic [DataW-1:0]  r_shadow_data;
  logic [DIGITS-1:0] r_shadow_dp;
  logic              r_load_ready;

  logic [DIGITS-1:0] r_anodes;
  logic [6:0]        r_cathodes;
  logic              r_dp_out;
  logic              r_frame_start;

  // ---------------------------------------------------------------------------
  // Combinational next-state
  // ---------------------------------------------------------------------------
  logic              w_scan_edge;
  logic              w_transfer;
  logic              w_commit;
  state_e            w_state_next;
  logic [IdxW-1:0]   w_idx_next;
  logic [CntW-1:0]   w_cnt_next;

  logic [DataW-1:0]  w_pend_data_next;
  logic [DIGITS-1:0] w_pend_dp_next;
  logic              w_pend_full_next;
  logic [DataW-1:0]  w_shadow_data_next;
  logic [DIGITS-1:0] w_shadow_dp_next;

  logic [3:0]        w_nibble;
  logic              w_digit_dark;
  logic [DIGITS-1:0] w_anodes_next;
  logic [6:0]        w_cathodes_next;
  logic              w_dp_out_next;

  assign w_scan_edge = i_scan_clock && !r_scan_prev;
  assign w_transfer  = i_load_valid && r_load_ready;

  // Scan FSM. A commit happens on every entry to SHOW with index 0.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_cnt_next   = r_cnt;
    w_commit     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_scan_edge) begin
          w_state_next = StShow;
          w_idx_next   = '0;
          w_commit     = 1'b1;
        end
      end
      StShow: begin
        if (w_scan_edge) begin
          w_state_next = StGap;
          w_cnt_next   = GapInit;
        end
      end
      StGap: begin
        // Scan edges are ignored here; the gap length is fixed.
        if (r_cnt == '0) begin
          w_state_next = StShow;
          if (r_idx == LastIdx) begin
            w_idx_next = '0;
            w_commit   = 1'b1;
          end else begin
            w_idx_next = r_idx + IdxW'(1);
          end
        end else begin
          w_cnt_next = r_cnt - CntW'(1);
        end
      end
      default: begin
        w_state_next = StIdle;
        w_idx_next   = '0;
      end
    endcase
  end

  // Pending/shadow update. When a transfer and a commit coincide, the commit
  // takes the old pending contents and the incoming value refills the slot.
  always_comb begin
    w_pend_data_next   = r_pend_data;
    w_pend_dp_next     = r_pend_dp;
    w_pend_full_next   = r_pend_full;
    w_shadow_data_next = r_shadow_data;
    w_shadow_dp_next   = r_shadow_dp;
    if (w_commit) begin
      if (r_pend_full) begin
        w_shadow_data_next = r_pend_data;
        w_shadow_dp_next   = r_pend_dp;
      end
      w_pend_full_next = 1'b0;
    end
    if (w_transfer) begin
      w_pend_data_next = i_load_data;
      w_pend_dp_next   = i_load_dp;
      w_pend_full_next = 1'b1;
    end
  end

  // Outputs are decoded from the next state so that the registered pins change
  // on the same edge as the FSM, one cycle after the scan edge is sampled.
  assign w_nibble = w_shadow_data_next[4*int'(w_idx_next) +: 4];

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  logic [IdxW-1:0] w_top_digit;
  assign w_top_digit  = top_nonzero(w_shadow_data_next);
  assign w_digit_dark = (w_idx_next > w_top_digit);
`else
  assign w_digit_dark = 1'b0;
`endif

  always_comb begin
    w_anodes_next   = '1;
    w_cathodes_next = 7'h7F;
    w_dp_out_next   = 1'b1;
    if (w_state_next == StShow) begin
      w_anodes_next[w_idx_next] = 1'b0;
      w_cathodes_next           = w_digit_dark ? 7'h7F : hex_to_seg(w_nibble);
      w_dp_out_next             = ~w_shadow_dp_next[w_idx_next];
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_cmos_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scan_prev <= 1'b0;
      r_state     <= StIdle;
      r_idx       <= '0;
      r_cnt       <= '0;
    end else begin
      r_scan_prev <= i_scan_clock;
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_cnt       <= w_cnt_next;
    end
  end

  always_ff @(posedge i_cmos_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_data   <= '0;
      r_pend_dp     <= '0;
      r_pend_full   <= 1'b0;
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_load_ready  <= 1'b1;
    end else begin
      r_pend_data   <= w_pend_data_next;
      r_pend_dp     <= w_pend_dp_next;
      r_pend_full   <= w_pend_full_next;
      r_shadow_data <= w_shadow_data_next;
      r_shadow_dp   <= w_shadow_dp_next;
      r_load_ready  <= !w_pend_full_next;
    end
  end

  always_ff @(posedge i_cmos_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_anodes      <= '1;
      r_cathodes    <= 7'h7F;
      r_dp_out      <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_anodes      <= w_anodes_next;
      r_cathodes    <= w_cathodes_next;
      r_dp_out      <= w_dp_out_next;
      r_frame_start <= w_commit;
    end
  end

  assign o_load_ready  = r_load_ready;
  assign o_anodes      = r_anodes;
  assign o_cathodes    = r_cathodes;
  assign o_dp_out      = r_dp_out;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_driver
//
// Scoreboard bench: each scan step pushes the digit it expects to see lit; a
// negedge monitor pops and compares whenever a new digit lights up, and checks
// blanking length, dark-cycle outputs and frameStart.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        scan;
  logic        load_valid;
  logic [31:0] load_data;
  logic [7:0]  load_dp;
  logic        load_ready;
  logic [7:0]  anodes;
  logic [6:0]  cathodes;
  logic        dp_out;
  logic        frame_start;

  int checks;
  int errors;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] cath;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];

  seven_seg_scan_driver #(
    .DIGITS       (8),
    .BLANK_CYCLES (16)
  ) u_dut (
    .i_cmos_clock  (clk),
    .i_rst_n       (rst_n),
    .i_scan_clock  (scan),
    .i_load_valid  (load_valid),
    .i_load_data   (load_data),
    .i_load_dp     (load_dp),
    .o_load_ready  (load_ready),
    .o_anodes      (anodes),
    .o_cathodes    (cathodes),
    .o_dp_out      (dp_out),
    .o_frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic prev_lit;
  logic gap_armed;
  int   gap_len;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_lit  = 1'b0;
      gap_armed = 1'b0;
      gap_len   = 0;
    end else begin
      if (anodes == 8'hFF) begin
        gap_len++;
        checks++;
        if (cathodes !== 7'h7F || dp_out !== 1'b1) begin
          errors++;
          $display("FAIL dark_outputs: cathodes %h dp %b, required 7f and 1", cathodes, dp_out);
        end
        checks++;
        if (frame_start !== 1'b0) begin
          errors++;
          $display("FAIL frame_start_dark: got %b, required 0", frame_start);
        end
      end else if (!prev_lit) begin
        if (gap_armed) begin
          checks++;
          if (gap_len != 16) begin
            errors++;
            $display("FAIL gap_length: %0d blank cycles, required 16", gap_len);
          end
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_digit: anodes %h cathodes %h lit with nothing expected",
                   anodes, cathodes);
        end else begin
          e = exp_q.pop_front();
          if (anodes !== e.an || cathodes !== e.cath || dp_out !== e.dp ||
              frame_start !== e.fs) begin
            errors++;
            $display("FAIL digit: an %h cath %h dp %b fs %b, required an %h cath %h dp %b fs %b",
                     anodes, cathodes, dp_out, frame_start, e.an, e.cath, e.dp, e.fs);
          end
        end
        gap_armed = 1'b1;
        gap_len   = 0;
      end else begin
        checks++;
        if (frame_start !== 1'b0) begin
          errors++;
          $display("FAIL frame_start_hold: got %b while digit held, required 0", frame_start);
        end
        gap_len = 0;
      end
      prev_lit = (anodes != 8'hFF);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    rst_n      = 1'b0;
    scan       = 1'b0;
    load_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] dp);
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_load: got %b, required 1", load_ready);
    end
    load_valid = 1'b1;
    load_data  = d;
    load_dp    = dp;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_load: got %b, required 0", load_ready);
    end
  endtask

  // One scan-clock rising edge, then enough cycles for gap + next digit. A
  // one-cycle load can be placed load_at cycles after the scan edge is driven.
  task automatic step_exp(input logic [7:0] an, input logic [6:0] cath, input logic dp,
                          input int load_at, input logic [31:0] ld, input logic [7:0] ldp);
    exp_t e;
    e.an   = an;
    e.cath = cath;
    e.dp   = dp;
    e.fs   = (an == 8'hFE);
    exp_q.push_back(e);
    for (int i = 0; i < 24; i++) begin
      if (i == 0) scan = 1'b1;
      if (i == 2) scan = 1'b0;
      if (load_at >= 0 && i == load_at) begin
        load_valid = 1'b1;
        load_data  = ld;
        load_dp    = ldp;
      end else if (load_at >= 0 && i == load_at + 1) begin
        load_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL digit_shown: %0d expected digit(s) never lit, next anodes %h",
               exp_q.size(), an);
      exp_q.delete();
    end
  endtask

  task automatic step(input int d, input logic [31:0] val, input logic [7:0] dpv);
    logic [7:0] an;
    an = ~(8'b1 << d);
    step_exp(an, seg_ref(val[4*d +: 4]), ~dpv[d], -1, 32'h0, 8'h0);
  endtask

  task automatic check_ready(input logic req, input string name);
    checks++;
    if (load_ready !== req) begin
      errors++;
      $display("FAIL %s: load_ready %b, required %b", name, load_ready, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    exp_t e;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      scan = ~scan;
      @(posedge clk);
      #1;
    end
    checks++;
    if (anodes !== 8'hFF || cathodes !== 7'h7F || dp_out !== 1'b1 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: an %h cath %h dp %b fs %b, required ff 7f 1 0",
               anodes, cathodes, dp_out, frame_start);
    end
    check_ready(1'b1, "reset_ready");
    scan  = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (anodes !== 8'hFF) begin
      errors++;
      $display("FAIL idle_dark: anodes %h, required ff", anodes);
    end
    e.an = 8'hFE; e.cath = 7'h40; e.dp = 1'b1; e.fs = 1'b1;
    exp_q.push_back(e);
    scan = 1'b1;
    @(negedge clk);
    checks++;
    if (anodes !== 8'hFF) begin
      errors++;
      $display("FAIL latency_early: anodes %h before sampling edge, required ff", anodes);
    end
    @(posedge clk);
    #1;
    checks++;
    if (anodes !== 8'hFE || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL first_digit: anodes %h fs %b, required fe 1", anodes, frame_start);
    end
    @(posedge clk);
    #1;
    scan = 1'b0;
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL frame_start_pulse: fs %b on second cycle, required 0", frame_start);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL first_digit_seen: %0d entries left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_scan_sequence();
    do_reset();
    load(32'h76543210, 8'h81);
    step(0, 32'h76543210, 8'h81);
    check_ready(1'b1, "ready_after_commit");
    for (int d = 1; d < 8; d++) step(d, 32'h76543210, 8'h81);
    step(0, 32'h76543210, 8'h81);
  endtask

  task automatic test_no_tear();
    for (int d = 1; d < 4; d++) step(d, 32'h76543210, 8'h81);
    load(32'h11111111, 8'h00);
    // Second value is held on the bus; it can only land after the commit.
    load_valid = 1'b1;
    load_data  = 32'h22222222;
    load_dp    = 8'h00;
    for (int d = 4; d < 8; d++) begin
      step(d, 32'h76543210, 8'h81);
      check_ready(1'b0, "ready_held_low");
    end
    step(0, 32'h11111111, 8'h00);
    check_ready(1'b0, "second_value_pending");
    load_valid = 1'b0;
    for (int d = 1; d < 8; d++) step(d, 32'h11111111, 8'h00);
    step(0, 32'h22222222, 8'h00);
    check_ready(1'b1, "ready_after_second_commit");
  endtask

  task automatic test_load_collision();
    for (int d = 1; d < 8; d++) step(d, 32'h22222222, 8'h00);
    // Transfer lands exactly on the commit cycle (16 cycles after the edge).
    step_exp(8'hFE, seg_ref(4'h2), 1'b1, 16, 32'hAAAAAAAA, 8'h00);
    check_ready(1'b0, "collision_pending");
    for (int d = 1; d < 8; d++) step(d, 32'h22222222, 8'h00);
    step(0, 32'hAAAAAAAA, 8'h00);
    check_ready(1'b1, "collision_committed");
  endtask

  task automatic test_mid_gap_reset();
    for (int d = 1; d < 6; d++) step(d, 32'hAAAAAAAA, 8'h00);
    load(32'h33333333, 8'hFF);
    scan = 1'b1;
    @(posedge clk);
    #1;
    scan = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (anodes !== 8'hFF) begin
      errors++;
      $display("FAIL in_gap: anodes %h, required ff", anodes);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (load_ready !== 1'b1 || anodes !== 8'hFF || cathodes !== 7'h7F || dp_out !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: ready %b an %h cath %h dp %b, required 1 ff 7f 1",
               load_ready, anodes, cathodes, dp_out);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 32'h00000000, 8'h00);
    check_ready(1'b1, "ready_after_reset_show");
  endtask

  task automatic test_leading_zero();
    logic [6:0] upper;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    upper = 7'h7F;
`else
    upper = 7'h40;
`endif
    do_reset();
    load(32'h000000A5, 8'h00);
    step_exp(8'hFE, 7'h12, 1'b1, -1, 32'h0, 8'h0);
    step_exp(8'hFD, 7'h08, 1'b1, -1, 32'h0, 8'h0);
    for (int d = 2; d < 8; d++) begin
      logic [7:0] an;
      an = ~(8'b1 << d);
      step_exp(an, upper, 1'b1, -1, 32'h0, 8'h0);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    scan       = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_dp    = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_scan_sequence();
    test_no_tear();
    test_load_collision();
    test_mid_gap_reset();
    test_leading_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Consumer end of the seven-segment clock chain: takes the slow toggling scan clock produced by the divider, detects its rising edges on the fast clock, and time-multiplexes a latched hex value across DIGITS common-anode digits. It inserts a blanking gap between digits to suppress ghosting. A frame-synchronised load handshake updates the display without tearing. It sits between the datapath (SD-card readout value) and the FPGA anode/cathode pins.

## Interface
- DIGITS, 8: number of multiplexed digits; data width is 4*DIGITS.
- BLANK_CYCLES, 16: cmosClock cycles with all anodes off between digits; must be ≥1.
- cmosClock  in  1  100 MHz system clock; all logic on rising edge.
- rstN  in  1  asynchronous, active-low reset.
- scanClock  in  1  divided scan clock, registered on cmosClock upstream; only its rising edges are used.
- loadValid  in  1  new value offered on loadData/loadDp.
- loadData  in  4*DIGITS  hex nibbles; nibble 0 (bits 3:0) is digit 0, the rightmost digit.
- loadDp  in  DIGITS  decimal-point enables, 1 = lit.
- loadReady  out  1  pending slot empty; a transfer occurs when loadValid && loadReady.
- anodes  out  DIGITS  active-low digit enables.
- cathodes  out  7  active-low segments {g,f,e,d,c,b,a}.
- dpOut  out  1  active-low decimal point.
- frameStart  out  1  one-cycle pulse when digit 0 is lit.

## Operation
- Edge detect: register scanClock into scanPrev; scanEdge = scanClock && !scanPrev. scanPrev resets to 0.
- Load path:
  - On a transfer, capture data and dp into the pending register, set pendFull, and drop loadReady.
  - At frame boundary (entry to SHOW with index 0), copy pending into shadow if pendFull, then clear pendFull.
  - loadReady = !pendFull, registered.
  - If a transfer and a commit fall in the same cycle, the commit uses the old pending and the new data becomes pending (pendFull stays 1).
- FSM:
  - IDLE: all outputs off. On scanEdge, go to SHOW, index = 0, commit pending.
  - SHOW: anodes[index] = 0, all others 1. Cathodes decode shadow nibble[index]; dpOut = ~shadowDp[index]. On scanEdge, go to GAP with gap counter = BLANK_CYCLES-1.
  - GAP: all anodes 1, cathodes 7'h7F, dpOut 1. Counter decrements each cycle. At 0: index = (index == DIGITS-1) ? 0 : index+1, go to SHOW, commit if the new index is 0.
  - scanEdge during GAP is ignored; the gap is not restarted or extended.
- Decode: standard hex 0–F; 0 = 7'b1000000, 8 = 7'b0000000, F = 7'b0001110.
- Index counter width is clog2(DIGITS). Wrap is explicit, so non-power-of-2 DIGITS never reach illegal indices.
- Reset mid-operation forces IDLE immediately, blanks the outputs, and clears pending and shadow.

## Timing
- Reset values:
  - anodes: all 1.
  - cathodes: 7'h7F.
  - dpOut: 1.
  - frameStart: 0.
  - loadReady: 1.
  - shadow, pending, index: 0.
  - pendFull: 0.
- All outputs are registered.
- Latency, scanClock rising (sampled at cycle N) to anodes change:
  - output updates at edge N+1.
  - IDLE→SHOW and SHOW→GAP both take 1 cycle.
- GAP lasts exactly BLANK_CYCLES cycles with anodes all 1.
- loadReady deasserts the cycle after a transfer and reasserts the cycle after the commit.
- frameStart is high for the single cycle in which SHOW index 0 is first driven.

## Configuration
- SEVENSEG_LEADING_ZERO_BLANK_EN:
  - Defined: any digit above the highest nonzero nibble of shadow stays dark in SHOW (anode still enabled, cathodes 7'h7F, dp still honoured). Digit 0 always shows, including for value 0.
  - Undefined: all digits always display their nibble.

## Test plan
- Reset: hold rstN=0 with scanClock toggling → anodes 8'hFF, cathodes 7'h7F, dpOut 1, loadReady 1; the first scanEdge after release lights anodes 8'hFE.
- Scan sequence: load 32'h76543210 in IDLE and toggle scanClock → per-digit cathodes 40,79,24,30,19,12,02,78 in order on anodes FE,FD,…,7F. Each digit change is preceded by exactly 16 blank cycles, and the sequence wraps to FE with frameStart pulsed.
- No tearing: load 32'h11111111 while digit 3 is lit, then 32'h22222222 → digits 3–7 keep the old value; the new value appears from digit 0 of the next frame. loadReady stays 0 until that commit.
- Load collision: assert loadValid with 32'hAAAAAAAA exactly on the commit cycle while pendFull → the old pending is displayed, AAAAAAAA becomes pending, and loadReady stays 0.
- Mid-GAP reset: pulse rstN low during GAP at index 5 → immediate blank and IDLE; the next scanEdge shows digit 0 with shadow 0 (cathodes 40).
- With SEVENSEG_LEADING_ZERO_BLANK_EN, load 32'h000000A5 → only digits 0–1 drive segments (12, 08); digits 2–7 output 7'h7F. Value 0 still shows "0" on digit 0.
